// File: rtl/kudu_perf_cnt_if.sv
// Dump stream of the Kudu performance-counter bank: one counter snapshot word per handshake.
// A word transfers on a rising clock edge with dump_valid_o & dump_ready_i; once valid rises, it and the payload hold until that edge.
interface kudu_perf_cnt_if #(
    parameter int CntWidth = 32
) ();
    logic                dump_valid_o;
    logic                dump_ready_i;
    logic [7:0]          dump_idx_o;
    logic [CntWidth-1:0] dump_data_o;
    logic                dump_sat_o;
    logic                dump_last_o;

    modport master (
        output dump_valid_o,
        output dump_idx_o,
        output dump_data_o,
        output dump_sat_o,
        output dump_last_o,
        input  dump_ready_i
    );

    modport slave (
        input  dump_valid_o,
        input  dump_idx_o,
        input  dump_data_o,
        input  dump_sat_o,
        input  dump_last_o,
        output dump_ready_i
    );
endinterface

// File: rtl/kudu_perf_cnt.sv
// Saturating performance-counter bank for the Kudu issuer's event pulses.
// Counter 0 counts enabled cycles; a snapshot freezes all counters into shadows that are streamed out.
module kudu_perf_cnt #(
    parameter int NumEvents = 16,
    parameter int CntWidth  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_stop_i,
    input  logic                 clear_i,
    input  logic [NumEvents-1:0] evt_i,
    input  logic                 snap_req_i,
    output logic                 cnt_en_o,
    output logic                 busy_o,
    kudu_perf_cnt_if.master      dump_if
);
    localparam int NumCnt = NumEvents + 1;
    localparam int IdxW = (NumCnt > 1) ? $clog2(NumCnt) : 1;
    localparam logic [7:0] LastIdx = 8'(NumEvents);
    localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        DUMP = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          idx_q, idx_d;
    logic                cnt_en_q, cnt_en_d;
    logic                snap_req_q;
    logic                snap_req;
    logic                capture;
    logic [NumCnt-1:0]   inc;
    logic [CntWidth-1:0] cnt_q [NumCnt];
    logic [CntWidth-1:0] cnt_d [NumCnt];
    logic [NumCnt-1:0]   sat_q, sat_d;
    logic [CntWidth-1:0] shd_cnt_q [NumCnt];
    logic [NumCnt-1:0]   shd_sat_q;

    assign snap_req = snap_req_i & ~snap_req_q;
    assign capture  = (state_q == IDLE) & snap_req;
    assign cnt_en_d = cnt_en_q ^ start_stop_i;
    assign inc      = {evt_i, 1'b1} & {NumCnt{cnt_en_q}};

    // Clear dominates; a counter already at all-ones holds and only raises its sticky flag.
    always_comb begin
        for (int i = 0; i < NumCnt; i++) begin
            cnt_d[i] = cnt_q[i];
            sat_d[i] = sat_q[i];
            if (clear_i) begin
                cnt_d[i] = '0;
                sat_d[i] = 1'b0;
            end else if (inc[i]) begin
                if (&cnt_q[i]) begin
                    sat_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CntOne;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (snap_req) begin
                    state_d = DUMP;
                    idx_d   = '0;
                end
            end
            DUMP: begin
                if (dump_if.dump_ready_i) begin
                    if (idx_q == LastIdx) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_en_q   <= 1'b0;
            snap_req_q <= 1'b0;
            sat_q      <= '0;
            shd_sat_q  <= '0;
            for (int i = 0; i < NumCnt; i++) begin
                cnt_q[i]     <= '0;
                shd_cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_en_q   <= cnt_en_d;
            snap_req_q <= snap_req_i;
            sat_q      <= sat_d;
            for (int i = 0; i < NumCnt; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            // Shadows take the pre-edge live values, so this cycle's increment is excluded.
            if (capture) begin
                shd_sat_q <= sat_q;
                for (int i = 0; i < NumCnt; i++) begin
                    shd_cnt_q[i] <= cnt_q[i];
                end
            end
        end
    end

    assign cnt_en_o             = cnt_en_q;
    assign busy_o               = (state_q == DUMP);
    assign dump_if.dump_valid_o = (state_q == DUMP);
    assign dump_if.dump_idx_o   = idx_q;
    assign dump_if.dump_data_o  = (state_q == DUMP) ? shd_cnt_q[idx_q[IdxW-1:0]] : '0;
    assign dump_if.dump_sat_o   = (state_q == DUMP) ? shd_sat_q[idx_q[IdxW-1:0]] : 1'b0;
    assign dump_if.dump_last_o  = (state_q == DUMP) && (idx_q == LastIdx);
endmodule

// File: tb/tb_kudu_perf_cnt.sv
// Bench for kudu_perf_cnt: a 32-bit and a 4-bit instance share stimulus; an event-count model feeds a scoreboard.
module tb_kudu_perf_cnt;
    localparam int NE = 16;
    localparam longint MaxA = 64'h0000_0000_FFFF_FFFF;
    localparam longint MaxB = 15;

    typedef struct packed {
        logic [7:0]  idx;
        logic [31:0] da;
        logic        sa;
        logic [3:0]  db;
        logic        sb;
        logic        last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_stop = 1'b0;
    logic          clear = 1'b0;
    logic          snap = 1'b0;
    logic          ready = 1'b0;
    logic [NE-1:0] evt = '0;
    logic          cnt_en_a, busy_a, cnt_en_b, busy_b;

    int checks = 0;
    int failures = 0;
    int ready_mode = 0;
    bit mon_on = 1'b0;

    // Reference model: unbounded event totals; saturation is derived when a snapshot is taken.
    longint m_cnt [NE+1];
    bit     m_en, m_busy, m_snap_q, m_was_busy;
    int     m_left;
    exp_t   exp_q [$];

    kudu_perf_cnt_if #(.CntWidth(32)) dif_a ();
    kudu_perf_cnt_if #(.CntWidth(4))  dif_b ();
    assign dif_a.dump_ready_i = ready;
    assign dif_b.dump_ready_i = ready;

    kudu_perf_cnt #(.NumEvents(NE), .CntWidth(32)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_stop_i(start_stop), .clear_i(clear),
        .evt_i(evt), .snap_req_i(snap), .cnt_en_o(cnt_en_a), .busy_o(busy_a),
        .dump_if(dif_a.master)
    );

    kudu_perf_cnt #(.NumEvents(NE), .CntWidth(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_stop_i(start_stop), .clear_i(clear),
        .evt_i(evt), .snap_req_i(snap), .cnt_en_o(cnt_en_b), .busy_o(busy_b),
        .dump_if(dif_b.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_snapshot();
        exp_t e;
        for (int i = 0; i <= NE; i++) begin
            e.idx  = 8'(i);
            e.sa   = (m_cnt[i] > MaxA);
            e.da   = e.sa ? 32'hFFFF_FFFF : m_cnt[i][31:0];
            e.sb   = (m_cnt[i] > MaxB);
            e.db   = e.sb ? 4'hF : m_cnt[i][3:0];
            e.last = (i == NE);
            exp_q.push_back(e);
        end
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i <= NE; i++) m_cnt[i] = 0;
            m_en = 0; m_busy = 0; m_snap_q = 0; m_left = 0;
            exp_q.delete();
        end else begin
            m_was_busy = m_busy;
            if (m_busy && ready) begin
                m_left--;
                if (m_left == 0) m_busy = 0;
            end
            if (!m_was_busy && snap && !m_snap_q) begin
                push_snapshot();
                m_busy = 1;
                m_left = NE + 1;
            end
            m_snap_q = snap;
            if (clear) begin
                for (int i = 0; i <= NE; i++) m_cnt[i] = 0;
            end else if (m_en) begin
                m_cnt[0]++;
                for (int k = 0; k < NE; k++) m_cnt[k+1] += longint'(evt[k]);
            end
            m_en ^= start_stop;
        end
    end

    // Monitor: per-cycle status, stall stability, and scoreboard pops on each handshake.
    bit          hold_on = 1'b0;
    logic [7:0]  h_idx_a, h_idx_b;
    logic [31:0] h_da;
    logic [3:0]  h_db;
    logic        h_sa, h_la, h_sb, h_lb;
    exp_t        got;

    always @(negedge clk) begin
        if (mon_on) begin
            chk("cnt_en_a", cnt_en_a, m_en);
            chk("cnt_en_b", cnt_en_b, m_en);
            chk("busy_a", busy_a, m_busy);
            chk("busy_b", busy_b, m_busy);
            chk("valid_a", dif_a.dump_valid_o, m_busy);
            chk("valid_b", dif_b.dump_valid_o, m_busy);
            if (hold_on) begin
                chk("stall_idx_a", dif_a.dump_idx_o, h_idx_a);
                chk("stall_data_a", dif_a.dump_data_o, h_da);
                chk("stall_sat_a", dif_a.dump_sat_o, h_sa);
                chk("stall_last_a", dif_a.dump_last_o, h_la);
                chk("stall_idx_b", dif_b.dump_idx_o, h_idx_b);
                chk("stall_data_b", dif_b.dump_data_o, h_db);
                chk("stall_sat_b", dif_b.dump_sat_o, h_sb);
                chk("stall_last_b", dif_b.dump_last_o, h_lb);
            end
            hold_on = dif_a.dump_valid_o && !ready && rst_n;
            if (hold_on) begin
                h_idx_a = dif_a.dump_idx_o; h_da = dif_a.dump_data_o;
                h_sa = dif_a.dump_sat_o;    h_la = dif_a.dump_last_o;
                h_idx_b = dif_b.dump_idx_o; h_db = dif_b.dump_data_o;
                h_sb = dif_b.dump_sat_o;    h_lb = dif_b.dump_last_o;
            end
            if (dif_a.dump_valid_o && ready) begin
                chk("word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    got = exp_q.pop_front();
                    chk($sformatf("idx_a@%0d", got.idx), dif_a.dump_idx_o, got.idx);
                    chk($sformatf("data_a@%0d", got.idx), dif_a.dump_data_o, got.da);
                    chk($sformatf("sat_a@%0d", got.idx), dif_a.dump_sat_o, got.sa);
                    chk($sformatf("last_a@%0d", got.idx), dif_a.dump_last_o, got.last);
                    chk($sformatf("idx_b@%0d", got.idx), dif_b.dump_idx_o, got.idx);
                    chk($sformatf("data_b@%0d", got.idx), dif_b.dump_data_o, got.db);
                    chk($sformatf("sat_b@%0d", got.idx), dif_b.dump_sat_o, got.sb);
                    chk($sformatf("last_b@%0d", got.idx), dif_b.dump_last_o, got.last);
                end
            end
        end
    end

    int rp = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: ready = 1'b1;
                1: begin
                    ready = (rp == 0);
                    rp = (rp + 1) % 3;
                end
                default: ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        step();
        while (m_busy && n < 400) begin
            step();
            n++;
        end
        chk("dump_timeout", m_busy, 0);
    endtask

    task automatic snapshot_and_wait();
        snap = 1'b1;
        step();
        snap = 1'b0;
        wait_idle();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        step();
        mon_on = 1'b1;
        chk("rst_cnt_en", cnt_en_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_valid", dif_a.dump_valid_o, 0);
        chk("rst_idx", dif_a.dump_idx_o, 0);
        chk("rst_data", dif_a.dump_data_o, 0);
        chk("rst_sat", dif_a.dump_sat_o, 0);
        chk("rst_last", dif_a.dump_last_o, 0);
        chk("rst_data_b", dif_b.dump_data_o, 0);
        step();
        rst_n = 1'b1;
        step(2);

        // Basic count
        pulse_ss();
        evt[0] = 1'b1; step(10); evt[0] = 1'b0;
        evt[3] = 1'b1; step(4);  evt[3] = 1'b0;
        pulse_ss();
        step(2);
        snapshot_and_wait();

        // Saturation of the 4-bit instance
        do_clear();
        pulse_ss();
        evt[2] = 1'b1; step(20); evt[2] = 1'b0;
        pulse_ss();
        snapshot_and_wait();

        // Backpressure with ready 1,0,0 repeating
        ready_mode = 1;
        pulse_ss();
        for (int i = 0; i < 12; i++) begin
            evt = NE'($urandom);
            step();
        end
        evt = '0;
        snapshot_and_wait();
        ready_mode = 0;

        // Clear colliding with an increment; enable stays on
        do_clear();
        evt[0] = 1'b1; step(7);
        clear = 1'b1; step();
        clear = 1'b0; evt = '0;
        step(3);
        snapshot_and_wait();

        // Snapshot isolation: events keep firing, requests during the dump are dropped
        ready_mode = 2;
        for (int i = 0; i < 5; i++) begin evt = NE'($urandom); step(); end
        snap = 1'b1; evt = NE'($urandom); step();
        snap = 1'b0;
        for (int i = 0; i < 8; i++) begin evt = NE'($urandom); step(); end
        snap = 1'b1;
        for (int i = 0; i < 10; i++) begin evt = NE'($urandom); step(); end
        snap = 1'b0;
        for (int i = 0; i < 3; i++) begin evt = NE'($urandom); step(); end
        evt = '0;
        wait_idle();
        step(2);
        snapshot_and_wait();
        ready_mode = 0;

        // Reset in the middle of a dump
        snap = 1'b1; step(); snap = 1'b0;
        for (int n = 0; n < 50 && dif_a.dump_idx_o != 8'd5; n++) step();
        chk("reached_idx5", dif_a.dump_idx_o, 5);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_valid", dif_a.dump_valid_o, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_cnt_en", cnt_en_a, 0);
        step(2);
        snapshot_and_wait();

        // Randomized traffic
        ready_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            evt = NE'($urandom);
            start_stop = ($urandom_range(0, 15) == 0);
            clear = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) snap = ~snap;
            step();
        end
        start_stop = 1'b0; clear = 1'b0; snap = 1'b0; evt = '0;
        wait_idle();
        step(2);
        chk("q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
